// File: rtl/amo_responder.sv
// Cache-side AMO responder: executes one atomic at a time as a read-modify-write
// on a single-ported data memory and tracks the LR/SC reservation.
//
// state   | meaning
// IDLE    | waiting for a request (ignored in the cycle right after an ack)
// RD_REQ  | read request outstanding, waiting for grant
// RD_WAIT | read granted, waiting for rvalid
// WR_REQ  | write request outstanding, waiting for grant
// RESP    | one-cycle ack carrying the result
module amo_responder #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned PLEN = 56
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            amo_req_i,
   input  logic [3:0]      amo_op_i,
   input  logic [1:0]      amo_size_i,
   input  logic [PLEN-1:0] amo_addr_i,
   input  logic [XLEN-1:0] amo_wdata_i,
   output logic            amo_ack_o,
   output logic [XLEN-1:0] amo_result_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [PLEN-1:0] mem_addr_o,
   output logic [7:0]      mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;

   localparam logic [3:0] OP_LR   = 4'd1;
   localparam logic [3:0] OP_SC   = 4'd2;
   localparam logic [3:0] OP_SWAP = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_MAX  = 4'd8;
   localparam logic [3:0] OP_MAXU = 4'd9;
   localparam logic [3:0] OP_MIN  = 4'd10;
   localparam logic [3:0] OP_MINU = 4'd11;

   state_e            state_q, state_d;
   logic [3:0]        op_q;
   logic              word_q;
   logic [PLEN-1:2]   addr_q;
   logic [XLEN-1:0]   operand_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   result_q;
   logic              res_valid_q;
   logic [PLEN-1:3]   res_addr_q;
   logic              ack_q;

   logic              accept;
   logic              sc_hit;
   logic              is_rmw_in;
   logic              word_in;
   logic [7:0]        lane_be;
   logic              unused_addr_lsb;

   assign accept          = amo_req_i && !ack_q;
   assign sc_hit          = res_valid_q && (res_addr_q == amo_addr_i[PLEN-1:3]);
   assign is_rmw_in       = (amo_op_i >= OP_SWAP) && (amo_op_i <= OP_MINU);
   assign word_in         = (amo_size_i == 2'd2);
   assign lane_be         = !word_q ? 8'hFF : (addr_q[2] ? 8'hF0 : 8'h0F);
   assign unused_addr_lsb = ^amo_addr_i[1:0];

   // Word operands are sign- or zero-extended to 64 bits so one comparator
   // and one adder serve both sizes.
   logic [31:0]     old_word;
   logic [XLEN-1:0] old_val, opnd_val, old_u, opnd_u, new_val, new_wdata;
   logic            old_lt_s, opnd_lt_s, old_lt_u, opnd_lt_u;

   always_comb begin
      old_word = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      if (word_q) begin
         old_val  = {{32{old_word[31]}}, old_word};
         opnd_val = {{32{operand_q[31]}}, operand_q[31:0]};
         old_u    = {32'd0, old_word};
         opnd_u   = {32'd0, operand_q[31:0]};
      end else begin
         old_val  = mem_rdata_i;
         opnd_val = operand_q;
         old_u    = mem_rdata_i;
         opnd_u   = operand_q;
      end
      old_lt_s  = $signed(old_val) < $signed(opnd_val);
      opnd_lt_s = $signed(opnd_val) < $signed(old_val);
      old_lt_u  = old_u < opnd_u;
      opnd_lt_u = opnd_u < old_u;
      case (op_q)
         OP_ADD:  new_val = old_val + opnd_val;
         OP_AND:  new_val = old_val & opnd_val;
         OP_OR:   new_val = old_val | opnd_val;
         OP_XOR:  new_val = old_val ^ opnd_val;
         OP_MAX:  new_val = old_lt_s  ? opnd_val : old_val;
         OP_MAXU: new_val = old_lt_u  ? opnd_val : old_val;
         OP_MIN:  new_val = opnd_lt_s ? opnd_val : old_val;
         OP_MINU: new_val = opnd_lt_u ? opnd_val : old_val;
         default: new_val = opnd_val;
      endcase
      new_wdata = word_q ? {new_val[31:0], new_val[31:0]} : new_val;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (amo_op_i == OP_LR || is_rmw_in) state_d = RD_REQ;
               else if (amo_op_i == OP_SC && sc_hit) state_d = WR_REQ;
               else state_d = RESP;
            end
         end
         RD_REQ:  if (mem_gnt_i) state_d = RD_WAIT;
         RD_WAIT: if (mem_rvalid_i) state_d = (op_q == OP_LR) ? RESP : WR_REQ;
         WR_REQ:  if (mem_gnt_i) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      amo_ack_o    = 1'b0;
      amo_result_o = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_be_o     = 8'h00;
      mem_wdata_o  = '0;
      case (state_q)
         RD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {addr_q[PLEN-1:3], 3'b000};
            mem_be_o   = 8'hFF;
         end
         WR_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {addr_q[PLEN-1:3], 3'b000};
            mem_be_o    = lane_be;
            mem_wdata_o = wdata_q;
         end
         RESP: begin
            amo_ack_o    = 1'b1;
            amo_result_o = result_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q        <= '0;
         word_q      <= 1'b0;
         addr_q      <= '0;
         operand_q   <= '0;
         wdata_q     <= '0;
         result_q    <= '0;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= (state_q == RESP);
         if (state_q == IDLE && accept) begin
            op_q      <= amo_op_i;
            word_q    <= word_in;
            addr_q    <= amo_addr_i[PLEN-1:2];
            operand_q <= amo_wdata_i;
            result_q  <= '0;
            if (amo_op_i == OP_SC) begin
               res_valid_q <= 1'b0;
               result_q    <= sc_hit ? '0 : XLEN'(1);
               wdata_q     <= word_in ? {amo_wdata_i[31:0], amo_wdata_i[31:0]} : amo_wdata_i;
            end
         end
         if (state_q == RD_WAIT && mem_rvalid_i) begin
            result_q <= old_val;
            wdata_q  <= new_wdata;
            if (op_q == OP_LR) begin
               res_valid_q <= 1'b1;
               res_addr_q  <= addr_q[PLEN-1:3];
            end else if (res_addr_q == addr_q[PLEN-1:3]) begin
               res_valid_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_amo_responder.sv
// Randomized self-checking bench for amo_responder with a behavioural memory
// and an operation-level reference model of the AMO and reservation rules.
module tb_amo_responder;
   localparam int unsigned XLEN = 64;
   localparam int unsigned PLEN = 56;
   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LR   = 4'd1;
   localparam logic [3:0] OP_SC   = 4'd2;
   localparam logic [3:0] OP_SWAP = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_MAX  = 4'd8;
   localparam logic [3:0] OP_MINU = 4'd11;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            amo_req_i;
   logic [3:0]      amo_op_i;
   logic [1:0]      amo_size_i;
   logic [PLEN-1:0] amo_addr_i;
   logic [XLEN-1:0] amo_wdata_i;
   logic            amo_ack_o;
   logic [XLEN-1:0] amo_result_o;
   logic            mem_req_o;
   logic            mem_we_o;
   logic [PLEN-1:0] mem_addr_o;
   logic [7:0]      mem_be_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [XLEN-1:0] mem_rdata_i;

   always #5 clk_i = ~clk_i;

   amo_responder #(.XLEN(XLEN), .PLEN(PLEN)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .amo_req_i    (amo_req_i),
      .amo_op_i     (amo_op_i),
      .amo_size_i   (amo_size_i),
      .amo_addr_i   (amo_addr_i),
      .amo_wdata_i  (amo_wdata_i),
      .amo_ack_o    (amo_ack_o),
      .amo_result_o (amo_result_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // backing store, memory-side handshake state and reference reservation
   logic [63:0]     mem_m [0:127];
   int              gnt_delay_rd = 0, gnt_delay_wr = 0, rv_lat = 1;
   bit              spur_en = 1'b0;
   int              n_rd = 0, n_wr = 0;
   logic [PLEN-1:0] last_raddr, last_waddr;
   logic [7:0]      last_wbe;
   logic [63:0]     last_wdata;
   bit              in_req = 1'b0, rd_pending = 1'b0;
   int              gnt_wait = 0, rd_cnt = 0;
   logic [63:0]     rd_data;
   logic [PLEN-1:0] snap_addr;
   logic            snap_we;
   logic [7:0]      snap_be;
   logic [63:0]     snap_wdata;
   bit              res_v = 1'b0;
   logic [52:0]     res_dw = '0;

   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) begin
            in_req = 1'b0; rd_pending = 1'b0;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            continue;
         end
         #1;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = {$urandom, $urandom};
         if (rd_pending) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rd_data;
               rd_pending   = 1'b0;
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mem_rvalid_i = 1'b1;
         end
         if (mem_req_o && !in_req) begin
            in_req     = 1'b1;
            gnt_wait   = mem_we_o ? gnt_delay_wr : gnt_delay_rd;
            snap_addr  = mem_addr_o;
            snap_we    = mem_we_o;
            snap_be    = mem_be_o;
            snap_wdata = mem_wdata_o;
         end
         mem_gnt_i = in_req && (gnt_wait == 0);
         if (in_req && gnt_wait > 0) gnt_wait--;
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && mem_req_o && mem_gnt_i) begin
            check("mem_stable", 64'(mem_addr_o == snap_addr && mem_we_o == snap_we &&
                  mem_be_o == snap_be && mem_wdata_o == snap_wdata), 64'd1);
            in_req = 1'b0;
            if (mem_we_o) begin
               n_wr++;
               last_waddr = mem_addr_o;
               last_wbe   = mem_be_o;
               last_wdata = mem_wdata_o;
               for (int b = 0; b < 8; b++)
                  if (mem_be_o[b]) mem_m[mem_addr_o[9:3]][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end else begin
               n_rd++;
               last_raddr = mem_addr_o;
               rd_data    = mem_m[mem_addr_o[9:3]];
               rd_cnt     = rv_lat;
               rd_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] ref_alu(input logic [3:0] op, input bit word,
                                            input logic [63:0] a, input logic [63:0] b);
      if (word) begin
         int sa, sb, r;
         int unsigned ua, ub;
         sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
         case (op)
            4'd3:    r = sb;
            4'd4:    r = sa + sb;
            4'd5:    r = sa & sb;
            4'd6:    r = sa | sb;
            4'd7:    r = sa ^ sb;
            4'd8:    r = (sb > sa) ? sb : sa;
            4'd9:    r = (ub > ua) ? sb : sa;
            4'd10:   r = (sb < sa) ? sb : sa;
            4'd11:   r = (ub < ua) ? sb : sa;
            default: r = sa;
         endcase
         return {32'd0, r};
      end else begin
         longint sa, sb, r;
         longint unsigned ua, ub;
         sa = a; sb = b; ua = a; ub = b;
         case (op)
            4'd3:    r = sb;
            4'd4:    r = sa + sb;
            4'd5:    r = sa & sb;
            4'd6:    r = sa | sb;
            4'd7:    r = sa ^ sb;
            4'd8:    r = (sb > sa) ? sb : sa;
            4'd9:    r = (ub > ua) ? sb : sa;
            4'd10:   r = (sb < sa) ? sb : sa;
            4'd11:   r = (ub < ua) ? sb : sa;
            default: r = sa;
         endcase
         return r;
      end
   endfunction

   task automatic do_amo(input string tag, input logic [3:0] op, input bit word,
                         input logic [PLEN-1:0] addr, input logic [63:0] opnd,
                         output logic [63:0] res_seen, output int lat_seen);
      int          idx, exp_lat, exp_rd, exp_wr, hold;
      logic [63:0] old_dw, old_v, new_dw, exp_res, exp_wd, nv;
      logic [31:0] lane_w;
      logic [7:0]  exp_be;
      bit          same, extra;
      idx    = int'(addr[9:3]);
      old_dw = mem_m[idx];
      lane_w = addr[2] ? old_dw[63:32] : old_dw[31:0];
      old_v  = word ? 64'(signed'(lane_w)) : old_dw;
      same   = res_v && (res_dw == addr[PLEN-1:3]);
      exp_rd = 0; exp_wr = 0; exp_res = '0; nv = '0; exp_lat = 1;
      if (op == OP_LR) begin
         exp_rd = 1; exp_res = old_v; exp_lat = 2 + gnt_delay_rd + rv_lat;
         res_v = 1'b1; res_dw = addr[PLEN-1:3];
      end else if (op == OP_SC) begin
         if (same) begin
            exp_wr = 1; nv = opnd; exp_lat = 2 + gnt_delay_wr;
         end else begin
            exp_res = 64'd1;
         end
         res_v = 1'b0;
      end else if (op >= OP_SWAP && op <= OP_MINU) begin
         exp_rd = 1; exp_wr = 1; exp_res = old_v;
         nv = ref_alu(op, word, old_v, opnd);
         exp_lat = 3 + gnt_delay_rd + rv_lat + gnt_delay_wr;
         if (same) res_v = 1'b0;
      end
      new_dw = old_dw; exp_be = 8'h00; exp_wd = '0;
      if (exp_wr != 0) begin
         if (word) begin
            exp_wd = {nv[31:0], nv[31:0]};
            exp_be = addr[2] ? 8'hF0 : 8'h0F;
            if (addr[2]) new_dw[63:32] = nv[31:0];
            else         new_dw[31:0]  = nv[31:0];
         end else begin
            exp_wd = nv; exp_be = 8'hFF; new_dw = nv;
         end
      end

      n_rd = 0; n_wr = 0;
      @(posedge clk_i); #1;
      amo_req_i   = 1'b1;
      amo_op_i    = op;
      amo_size_i  = word ? 2'd2 : 2'd3;
      amo_addr_i  = addr;
      amo_wdata_i = opnd;
      lat_seen = -1; res_seen = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_i);
         if (amo_ack_o) begin
            lat_seen = c; res_seen = amo_result_o;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat_seen), 64'(exp_lat));
      check({tag, " result"}, res_seen, exp_res);

      // optionally keep the request up through the post-ack cycle
      hold = $urandom_range(0, 1); extra = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         if (k == hold) begin
            amo_req_i   = 1'b0;
            amo_op_i    = 4'($urandom);
            amo_addr_i  = {$urandom, $urandom};
            amo_wdata_i = {$urandom, $urandom};
         end
         @(negedge clk_i);
         if (amo_ack_o || mem_req_o) extra = 1'b1;
      end
      check({tag, " no_reissue"}, 64'(extra), 64'd0);
      check({tag, " reads"}, 64'(n_rd), 64'(exp_rd));
      check({tag, " writes"}, 64'(n_wr), 64'(exp_wr));
      if (exp_rd != 0) check({tag, " raddr"}, 64'(last_raddr), 64'({addr[PLEN-1:3], 3'b000}));
      if (exp_wr != 0) begin
         check({tag, " waddr"}, 64'(last_waddr), 64'({addr[PLEN-1:3], 3'b000}));
         check({tag, " wbe"}, 64'(last_wbe), 64'(exp_be));
         check({tag, " wdata"}, last_wdata, exp_wd);
      end
      check({tag, " mem"}, mem_m[idx], new_dw);
   endtask

   logic [63:0] r;
   int          l;
   logic [63:0] keep;
   bit          ack_in_rst;

   initial begin
      rst_ni = 1'b0;
      amo_req_i = 1'b0; amo_op_i = '0; amo_size_i = '0; amo_addr_i = '0; amo_wdata_i = '0;
      for (int i = 0; i < 128; i++) mem_m[i] = {$urandom, $urandom};
      #12;
      check("reset ack", 64'(amo_ack_o), 64'd0);
      check("reset result", amo_result_o, 64'd0);
      check("reset mem_out", 64'({mem_req_o, mem_we_o, mem_be_o, |mem_addr_o, |mem_wdata_o}), 64'd0);
      #10 rst_ni = 1'b1;

      mem_m[16] = 64'd5;
      do_amo("add_d", OP_ADD, 1'b0, 56'h80, 64'd3, r, l);
      check("add_d const_result", r, 64'd5);
      check("add_d const_latency", 64'(l), 64'd4);
      check("add_d const_wdata", last_wdata, 64'd8);

      mem_m[16] = 64'hFFFF_FFFE_0000_0001;
      do_amo("max_w", OP_MAX, 1'b1, 56'h84, 64'h0000_0000_0000_0007, r, l);
      check("max_w const_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
      check("max_w const_wdata", last_wdata, 64'h0000_0007_0000_0007);
      check("max_w const_be", 64'(last_wbe), 64'hF0);

      do_amo("lr_d", OP_LR, 1'b0, 56'h100, 64'd0, r, l);
      do_amo("sc_d", OP_SC, 1'b0, 56'h100, 64'hAB, r, l);
      check("sc_d const_result", r, 64'd0);
      check("sc_d const_latency", 64'(l), 64'd2);
      check("sc_d const_mem", mem_m[32], 64'hAB);
      do_amo("sc_d2", OP_SC, 1'b0, 56'h100, 64'hCD, r, l);
      check("sc_d2 const_result", r, 64'd1);
      check("sc_d2 const_latency", 64'(l), 64'd1);

      do_amo("lr_w", OP_LR, 1'b1, 56'h200, 64'd0, r, l);
      do_amo("swap_d", OP_SWAP, 1'b0, 56'h200, 64'h1122_3344_5566_7788, r, l);
      do_amo("sc_w", OP_SC, 1'b1, 56'h200, 64'h99, r, l);
      check("sc_w const_result", r, 64'd1);
      check("sc_w const_mem", mem_m[64], 64'h1122_3344_5566_7788);

      do_amo("none", OP_NONE, 1'b0, 56'h40, 64'd7, r, l);
      do_amo("cas", 4'd12, 1'b0, 56'h40, 64'd7, r, l);

      gnt_delay_rd = 3; rv_lat = 2; gnt_delay_wr = 3;
      do_amo("stall_add", OP_ADD, 1'b0, 56'h88, 64'd11, r, l);
      check("stall const_latency", 64'(l), 64'd11);

      // reset while a read is outstanding after an LR set the reservation
      gnt_delay_rd = 0; rv_lat = 1; gnt_delay_wr = 0;
      do_amo("lr_pre", OP_LR, 1'b0, 56'h300, 64'd0, r, l);
      keep = mem_m[97];
      rv_lat = 3; n_rd = 0;
      @(posedge clk_i); #1;
      amo_req_i = 1'b1; amo_op_i = OP_ADD; amo_size_i = 2'd3; amo_addr_i = 56'h308; amo_wdata_i = 64'd1;
      for (int c = 0; c < 20 && n_rd == 0; c++) @(negedge clk_i);
      check("rst_mid read_seen", 64'(n_rd), 64'd1);
      @(posedge clk_i); #2;
      rst_ni = 1'b0;
      #1;
      check("rst_mid ack", 64'(amo_ack_o), 64'd0);
      check("rst_mid mem_req", 64'(mem_req_o), 64'd0);
      check("rst_mid outs", 64'({mem_we_o, mem_be_o, |mem_addr_o, |mem_wdata_o, |amo_result_o}), 64'd0);
      amo_req_i = 1'b0;
      res_v = 1'b0;
      ack_in_rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         if (amo_ack_o) ack_in_rst = 1'b1;
      end
      check("rst_mid no_ack", 64'(ack_in_rst), 64'd0);
      rst_ni = 1'b1;
      check("rst_mid mem_kept", mem_m[97], keep);
      rv_lat = 1;
      do_amo("sc_after_rst", OP_SC, 1'b0, 56'h300, 64'h55, r, l);
      check("sc_after_rst const_result", r, 64'd1);

      spur_en = 1'b1;
      for (int t = 0; t < 300; t++) begin
         logic [3:0]      op;
         bit              word;
         logic [PLEN-1:0] addr;
         int              sel;
         sel = $urandom_range(0, 9);
         if (sel < 2)      op = OP_LR;
         else if (sel < 4) op = OP_SC;
         else              op = 4'($urandom_range(0, 13));
         word = 1'($urandom_range(0, 1));
         addr = '0;
         addr[5:3] = 3'($urandom_range(0, 7));
         addr[2]   = word ? 1'($urandom_range(0, 1)) : 1'b0;
         gnt_delay_rd = $urandom_range(0, 3);
         gnt_delay_wr = $urandom_range(0, 3);
         rv_lat       = $urandom_range(1, 3);
         do_amo($sformatf("rand%0d", t), op, word, addr, {$urandom, $urandom}, r, l);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/amo_responder.md
Name: amo_responder

Overview:
- Cache-side responder for the AMO request/response interface that the store unit's AMO buffer drives.
- Accepts one atomic request at a time and performs the read-modify-write on a single-ported data memory interface.
- Maintains the LR/SC reservation and returns the old memory value, or the SC status, with a one-cycle ack.
- Sits between the LSU AMO path and the D$ / memory backend.

Parameters:
XLEN, 64, data width in bits; only 64 is supported.
PLEN, 56, physical address width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
amo_req_i  in  1  request valid; held with stable payload until amo_ack_o
amo_op_i  in  4  amo_t encoding: NONE=0 LR=1 SC=2 SWAP=3 ADD=4 AND=5 OR=6 XOR=7 MAX=8 MAXU=9 MIN=10 MINU=11; CAS1/CAS2=12/13
amo_size_i  in  2  2=word, 3=doubleword
amo_addr_i  in  PLEN  physical address, naturally aligned
amo_wdata_i  in  XLEN  operand, word operand in bits [31:0]
amo_ack_o  out  1  single-cycle completion pulse
amo_result_o  out  XLEN  old value or SC status; valid only while amo_ack_o is high
mem_req_o  out  1  memory request; held until mem_gnt_i
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  PLEN  doubleword-aligned address (amo_addr_i with [2:0]=0)
mem_be_o  out  8  byte enables
mem_wdata_o  out  XLEN  write data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid; earliest one cycle after the read grant
mem_rdata_i  in  XLEN  read data

Behaviour:
- Reset: state IDLE. amo_ack_o, amo_result_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are all 0. Reservation is invalid.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE, on amo_req_i: register op, size, addr and wdata. Next state:
  - LR or read-modify-write op: RD_REQ.
  - SC with a valid reservation whose addr[PLEN-1:3] matches: WR_REQ.
  - SC otherwise: RESP with result 1.
  - NONE or CAS: RESP with result 0, no memory access.
- IDLE ignores amo_req_i in the cycle immediately after an ack, so a held request cannot be double-issued.
- RD_REQ: mem_req_o=1, we=0, be=0xFF. Go to RD_WAIT on mem_gnt_i.
- RD_WAIT: on mem_rvalid_i, capture the old value.
  - LR: set reservation valid with the captured address, then go to RESP.
  - Otherwise: compute the new value, then go to WR_REQ.
- WR_REQ: mem_req_o=1, we=1. Go to RESP on mem_gnt_i; no write response is expected.
- RESP: amo_ack_o=1 for exactly one cycle, amo_result_o driven, then IDLE.
- Word ops:
  - Lane select is addr[2].
  - Old value is mem_rdata_i[32*addr[2] +: 32].
  - Write data is the new 32-bit value replicated into both halves.
  - be = 0x0F when addr[2]=0, 0xF0 when addr[2]=1.
  - Result is the old word sign-extended to 64 bits.
- Doubleword ops: be=0xFF, result is the full old value.
- ALU:
  - SWAP: new = operand.
  - ADD: modular add, truncated to the operand width.
  - AND / OR / XOR: bitwise.
  - MAX / MIN: signed compare at the operand width.
  - MAXU / MINU: unsigned compare at the operand width.
  - Equal values: keep the old value.
- SC success: write the operand, result 0.
- Reservation rules:
  - Any SC clears the reservation, whether it succeeds or fails.
  - Any read-modify-write AMO to the reserved doubleword clears it.
  - An LR overwrites any existing reservation.
- Zero-wait memory latency (gnt in the same cycle, rvalid in the next), counted from the cycle amo_req_i is sampled in IDLE (cycle 0):
  - Read-modify-write: ack at cycle 4.
  - LR: ack at cycle 3.
  - SC success: ack at cycle 2.
  - SC fail, NONE, CAS: ack at cycle 1.
- Stalls: a missing mem_gnt_i holds the current state with all mem outputs stable. mem_rvalid_i outside RD_WAIT is ignored.
- Misalignment is not checked here; it is trapped upstream.
- Reset mid-operation returns to IDLE immediately, drops mem_req_o and clears the reservation. No ack is issued.

Test Plan:
- AMOADD.D, addr 0x80, mem[0x80]=5, operand 3, zero-wait memory -> read then write 8 with be=0xFF, ack at cycle 4, result 5.
- AMOMAX.W, addr 0x84, mem dword 0xFFFFFFFE_00000001, operand 0x00000007 -> write data 0x00000007_00000007 with be=0xF0, result 0xFFFFFFFF_FFFFFFFE.
- LR.D 0x100, then SC.D 0x100 operand 0xAB -> SC ack at cycle 2, result 0, write 0xAB. A second SC.D 0x100 -> result 1, no mem_req_o, ack at cycle 1.
- LR.W 0x200, then AMOSWAP.D 0x200, then SC.W 0x200 -> SC result 1, mem unchanged by the SC.
- mem_gnt_i held low 3 cycles in RD_REQ and WR_REQ, rvalid delayed 2 cycles -> mem outputs stable while waiting, ack at cycle 11, result correct.
- rst_ni asserted during RD_WAIT after an LR had set the reservation -> all outputs 0 immediately, no ack. A subsequent SC -> result 1.
